// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
//   Seven-segment display controller. Picks one of three 14-bit parameter
//   values (frequency, amplitude, duty) by MODE, saturates it to 9999, converts
//   it to packed BCD with a sequential shift-add-3 engine and commits BCD,
//   decimal-point index and overflow flag together. Also divides CLK down to
//   the digit-scan clock.
//
// Ports
//   CLK        in   system clock
//   RESET_N    in   asynchronous active-low reset
//   MODE       in   [1:0]  00 FREQ, 01 AMP, 10 DUTY, 11 blank
//   FREQ/AMP/DUTY          in [13:0] unsigned source values
//   FREQ_DP/AMP_DP/DUTY_DP in [1:0]  decimal-point digit index per source
//   BCD        out  [15:0] packed BCD, [3:0] least significant digit
//   DECIMAL    out  [1:0]  decimal-point digit index
//   OVER       out  displayed value was saturated
//   BUSY       out  conversion in progress
//   SCAN_CLK   out  digit-scan clock, 50% duty, period 2*SCAN_DIV
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
   parameter int SCAN_DIV   = 100000,
   parameter int UPDATE_DIV = 10000000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [1:0]  MODE,
   input  logic [13:0] FREQ,
   input  logic [13:0] AMP,
   input  logic [13:0] DUTY,
   input  logic [1:0]  FREQ_DP,
   input  logic [1:0]  AMP_DP,
   input  logic [1:0]  DUTY_DP,
   output logic [15:0] BCD,
   output logic [1:0]  DECIMAL,
   output logic        OVER,
   output logic        BUSY,
   output logic        SCAN_CLK
);

   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int UPW = $clog2(UPDATE_DIV);
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [UPW-1:0] UPD_LAST  = UPW'(UPDATE_DIV - 1);
   localparam logic [13:0]    MAX_VAL   = 14'd9999;
   localparam logic [1:0]     MODE_BLANK = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_COMMIT
   } state_t;

   state_t          r_state;
   logic [SCW-1:0]  r_scan_cnt;
   logic            r_scan_clk;
   logic [UPW-1:0]  r_upd_cnt;
   logic            r_pending;
   logic [1:0]      r_last_mode;
   logic [13:0]     r_operand;
   logic [15:0]     r_acc;
   logic [3:0]      r_iter;
   logic            r_ovf;
   logic [1:0]      r_dp;
   logic [15:0]     r_bcd;
   logic [1:0]      r_decimal;
   logic            r_over;
   logic            r_busy;

   logic            w_tick;
   logic            w_mode_chg;
   logic            w_req;
   logic [13:0]     w_sel_val;
   logic [1:0]      w_sel_dp;
   logic [15:0]     w_acc_adj;

   assign BCD      = r_bcd;
   assign DECIMAL  = r_decimal;
   assign OVER     = r_over;
   assign BUSY     = r_busy;
   assign SCAN_CLK = r_scan_clk;

   // Scan divider: free-running, independent of the conversion FSM.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_scan_cnt <= '0;
         r_scan_clk <= 1'b0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_scan_clk <= ~r_scan_clk;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   // Periodic refresh timer.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_upd_cnt <= '0;
      end else if (r_upd_cnt == UPD_LAST) begin
         r_upd_cnt <= '0;
      end else begin
         r_upd_cnt <= r_upd_cnt + 1'b1;
      end
   end

   assign w_tick     = (r_upd_cnt == UPD_LAST);
   assign w_mode_chg = (MODE != r_last_mode);
   assign w_req      = w_tick | w_mode_chg | r_pending;

   always_comb begin
      w_sel_val = '0;
      w_sel_dp  = '0;
      case (MODE)
         2'b00: begin w_sel_val = FREQ; w_sel_dp = FREQ_DP; end
         2'b01: begin w_sel_val = AMP;  w_sel_dp = AMP_DP;  end
         2'b10: begin w_sel_val = DUTY; w_sel_dp = DUTY_DP; end
         default: begin w_sel_val = '0; w_sel_dp = '0; end
      endcase
   end

   // Add 3 to every BCD nibble >= 5 ahead of the shift.
   always_comb begin
      w_acc_adj = r_acc;
      for (int unsigned i = 0; i < 4; i++) begin
         if (r_acc[i*4 +: 4] >= 4'd5) begin
            w_acc_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_pending   <= 1'b1;
         r_last_mode <= '0;
         r_operand   <= '0;
         r_acc       <= '0;
         r_iter      <= '0;
         r_ovf       <= 1'b0;
         r_dp        <= '0;
         r_bcd       <= '1;
         r_decimal   <= '0;
         r_over      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // While busy, remember any request for after the current commit.
         // last_mode is only refreshed at the end of LOAD, so the mode
         // comparison is ignored in LOAD to avoid re-triggering on the very
         // change that started this conversion.
         if (r_state != S_IDLE) begin
            if (w_tick || ((r_state != S_LOAD) && w_mode_chg)) begin
               r_pending <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_state   <= S_LOAD;
                  r_busy    <= 1'b1;
                  r_pending <= 1'b0;
               end
            end
            S_LOAD: begin
               r_last_mode <= MODE;
               r_dp        <= w_sel_dp;
               if (w_sel_val > MAX_VAL) begin
                  r_operand <= MAX_VAL;
                  r_ovf     <= 1'b1;
               end else begin
                  r_operand <= w_sel_val;
                  r_ovf     <= 1'b0;
               end
               r_acc   <= '0;
               r_iter  <= '0;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_acc     <= {w_acc_adj[14:0], r_operand[13]};
               r_operand <= {r_operand[12:0], 1'b0};
               r_iter    <= r_iter + 1'b1;
               if (r_iter == 4'd13) begin
                  r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               if (r_last_mode == MODE_BLANK) begin
                  r_bcd     <= '1;
                  r_decimal <= '0;
                  r_over    <= 1'b0;
               end else begin
                  r_bcd     <= r_acc;
                  r_decimal <= r_dp;
                  r_over    <= r_ovf;
               end
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [1:0]  MODE;
   logic [13:0] FREQ, AMP, DUTY;
   logic [1:0]  FREQ_DP, AMP_DP, DUTY_DP;
   logic [15:0] BCD;
   logic [1:0]  DECIMAL;
   logic        OVER, BUSY, SCAN_CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int ph      = 0;

   typedef struct packed {
      logic [15:0] bcd;
      logic [1:0]  dec;
      logic        over;
   } exp_t;

   exp_t sb[$];

   seg_display_ctrl #(.SCAN_DIV(4), .UPDATE_DIV(64)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .MODE(MODE),
      .FREQ(FREQ), .AMP(AMP), .DUTY(DUTY),
      .FREQ_DP(FREQ_DP), .AMP_DP(AMP_DP), .DUTY_DP(DUTY_DP),
      .BCD(BCD), .DECIMAL(DECIMAL), .OVER(OVER), .BUSY(BUSY),
      .SCAN_CLK(SCAN_CLK)
   );

   always #5 CLK = ~CLK;

   // Refresh-timer phase model: tick happens in the cycle where ph == 63.
   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) ph <= 0;
      else          ph <= (ph == 63) ? 0 : ph + 1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] bcd, input logic [1:0] dec, input logic over);
      exp_t e;
      e.bcd = bcd; e.dec = dec; e.over = over;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      logic have;
      have = (sb.size() != 0);
      chk({tag, "_sb"}, {15'd0, have}, 16'd1);
      if (have) begin
         e = sb.pop_front();
         chk({tag, "_bcd"}, BCD, e.bcd);
         chk({tag, "_dec"}, {14'd0, DECIMAL}, {14'd0, e.dec});
         chk({tag, "_over"}, {15'd0, OVER}, {15'd0, e.over});
      end
   endtask

   // Waits for BUSY to fall (first cycle after a commit edge), then scores it.
   task automatic wait_commit(input string tag, input int bound);
      logic prev;
      logic done;
      prev = BUSY;
      done = 1'b0;
      for (int i = 1; i <= bound; i++) begin
         @(negedge CLK);
         if (prev && !BUSY) begin
            done = 1'b1;
            break;
         end
         prev = BUSY;
      end
      chk({tag, "_commit"}, {15'd0, done}, 16'd1);
      if (done) pop_check(tag);
   endtask

   task automatic wait_phase(input int k);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         if (ph == k) begin
            hit = 1'b1;
            break;
         end
      end
      chk("phase_sync", {15'd0, hit}, 16'd1);
   endtask

   initial begin
      int sweep_in[5];
      logic [15:0] sweep_bcd[5];
      sweep_in  = '{0, 9, 10, 999, 9999};
      sweep_bcd = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h9999};

      RESET_N = 1'b0;
      MODE = 2'b00;
      FREQ = 14'd1234; AMP = 14'd0; DUTY = 14'd0;
      FREQ_DP = 2'd2; AMP_DP = 2'd3; DUTY_DP = 2'd0;

      // Reset values
      repeat (3) @(negedge CLK);
      chk("rst_bcd", BCD, 16'hFFFF);
      chk("rst_dec", {14'd0, DECIMAL}, 16'd0);
      chk("rst_over", {15'd0, OVER}, 16'd0);
      chk("rst_busy", {15'd0, BUSY}, 16'd0);
      chk("rst_scan", {15'd0, SCAN_CLK}, 16'd0);

      // First conversion after release: LOAD on edge 1, outputs after edge 17
      RESET_N = 1'b1;
      push(16'h1234, 2'd2, 1'b0);
      @(negedge CLK);
      chk("first_load_busy", {15'd0, BUSY}, 16'd1);
      repeat (15) @(negedge CLK);
      chk("commit_busy", {15'd0, BUSY}, 16'd1);
      chk("hold_before_commit", BCD, 16'hFFFF);
      @(negedge CLK);
      chk("first_done_busy", {15'd0, BUSY}, 16'd0);
      pop_check("first_conv");

      // Conversion sweep, one value per tick
      for (int i = 0; i < 5; i++) begin
         wait_phase(20);
         FREQ = 14'(sweep_in[i]);
         push(sweep_bcd[i], 2'd2, 1'b0);
         wait_commit("sweep", 80);
      end

      // Saturation, then back in range on the next tick
      wait_phase(20);
      MODE = 2'b01; AMP = 14'h3FFF; AMP_DP = 2'd3;
      push(16'h9999, 2'd3, 1'b1);
      wait_commit("sat", 18);
      AMP = 14'd5000;
      push(16'h5000, 2'd3, 1'b0);
      wait_commit("unsat", 80);

      // Mode change without tick, then blank
      wait_phase(20);
      MODE = 2'b00;
      push(16'h9999, 2'd2, 1'b0);
      wait_commit("mode_freq", 18);
      DUTY = 14'd50; DUTY_DP = 2'd1; MODE = 2'b10;
      push(16'h0050, 2'd1, 1'b0);
      wait_commit("mode_duty", 17);
      MODE = 2'b11;
      push(16'hFFFF, 2'd0, 1'b0);
      wait_commit("blank", 17);
      // A tick landed during the blank conversion: one pending repeat follows
      push(16'hFFFF, 2'd0, 1'b0);
      wait_commit("blank_pend", 20);

      // Pending collision: MODE changes while BUSY
      wait_phase(20);
      MODE = 2'b00;
      push(16'h9999, 2'd2, 1'b0);
      repeat (5) @(negedge CLK);
      MODE = 2'b01;
      push(16'h5000, 2'd3, 1'b0);
      wait_commit("coll_first", 20);
      @(negedge CLK);
      chk("coll_reload_busy", {15'd0, BUSY}, 16'd1);
      wait_commit("coll_second", 20);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("coll_no_extra", {15'd0, BUSY}, 16'd0);
      end

      // Reset during SHIFT, then scan clock and forced reconversion
      wait_phase(20);
      MODE = 2'b00;
      repeat (5) @(negedge CLK);
      chk("pre_rst_busy", {15'd0, BUSY}, 16'd1);
      chk("pre_rst_bcd", BCD, 16'h5000);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_bcd", BCD, 16'hFFFF);
      chk("mid_rst_dec", {14'd0, DECIMAL}, 16'd0);
      chk("mid_rst_over", {15'd0, OVER}, 16'd0);
      chk("mid_rst_busy", {15'd0, BUSY}, 16'd0);
      MODE = 2'b01;
      repeat (2) @(negedge CLK);
      chk("mid_rst_scan", {15'd0, SCAN_CLK}, 16'd0);
      RESET_N = 1'b1;
      push(16'h5000, 2'd3, 1'b0);
      for (int i = 1; i <= 17; i++) begin
         @(negedge CLK);
         chk("scan_clk", {15'd0, SCAN_CLK}, 16'((i / 4) % 2));
         if (i == 16) chk("post_rst_hold", BCD, 16'hFFFF);
      end
      pop_check("post_rst_conv");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Display controller for the Basys3 four-digit seven-segment path. It selects one of three binary parameter values (frequency, amplitude, duty) by MODE and converts it to packed BCD with a sequential shift-add-3 engine. It registers BCD and decimal-point position atomically and generates the slow scan clock that steps the digit multiplexer. It sits between the signal-generator parameter registers and the seven-segment digit driver: its BCD, DECIMAL and SCAN_CLK outputs feed that driver's BCD, DECIMAL and CLK inputs.

## Interface
- SCAN_DIV, 100000: half-period of SCAN_CLK in CLK cycles; must be ≥1.
- UPDATE_DIV, 10000000: CLK cycles between periodic display refreshes; must be ≥32.
- CLK  in  1  system clock, 100 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- MODE  in  2  source select: 00 FREQ, 01 AMP, 10 DUTY, 11 blank.
- FREQ  in  14  unsigned frequency value.
- AMP  in  14  unsigned amplitude value.
- DUTY  in  14  unsigned duty value.
- FREQ_DP, AMP_DP, DUTY_DP  in  2 each  digit index whose decimal point is lit for that source.
- BCD  out  16  four packed BCD digits; [3:0] is the least significant digit.
- DECIMAL  out  2  decimal-point digit index.
- OVER  out  1  the displayed value was saturated.
- BUSY  out  1  a conversion is in progress.
- SCAN_CLK  out  1  digit-scan clock, 50% duty.

## Operation
- **Reset values:** BCD=16'hFFFF (all digits show a dash), DECIMAL=2'b00, OVER=0, BUSY=0, SCAN_CLK=0. State=IDLE, all counters 0, pending=1.
- **Scan divider:** counter runs 0..SCAN_DIV-1. On the terminal count it wraps to 0 and SCAN_CLK toggles. SCAN_CLK period = 2·SCAN_DIV cycles. It is never stalled by the FSM.
- **Update timer:** counter runs 0..UPDATE_DIV-1. tick=1 for the single cycle in which count==UPDATE_DIV-1. It is free-running.
- **Start request:** a request is tick OR (MODE != last_mode) OR pending.
  - A request seen while BUSY=1 sets pending and is not lost.
  - pending clears when IDLE starts a conversion.
- **FSM states:**
  - IDLE: on a request, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): latch MODE into last_mode. Latch the selected value and its DP.
    - If the value is >9999, latch 9999 and ovf=1; otherwise latch the value and ovf=0.
    - Clear the 16-bit BCD accumulator and the iteration count. Go to SHIFT.
  - SHIFT (14 cycles): each cycle, add 3 to every accumulator nibble ≥5, then shift {accumulator, operand} left by 1. After the 14th cycle go to COMMIT.
  - COMMIT (1 cycle): write the outputs on the edge that leaves COMMIT, then go to IDLE.
    - Normal modes: BCD=accumulator, DECIMAL=latched DP, OVER=ovf.
    - Blank mode (11): BCD=16'hFFFF, DECIMAL=2'b00, OVER=0.
- **BUSY** is 1 in LOAD, SHIFT and COMMIT, and 0 in IDLE.
- **Input sampling:** FREQ, AMP, DUTY and the DP inputs are sampled only in LOAD. Changes during SHIFT or COMMIT do not affect the conversion in flight.
- **Atomic update:** BCD, DECIMAL and OVER change together and only on the COMMIT edge; they are held between commits.
- **Simultaneous events:** a MODE change in the same cycle as tick gives one conversion, not two.
- **Reset mid-conversion:** all state returns to reset values immediately. After release, pending=1 forces a fresh conversion.

## Timing
- A request seen in IDLE in cycle n gives: LOAD in n+1, SHIFT in n+2..n+15, COMMIT in n+16, new outputs visible in n+17.
- Request-to-display latency is 17 cycles. BUSY is high for 16 cycles.
- Back-to-back conversions (pending set): the next LOAD starts at n+18, because one IDLE cycle sits between conversions.
- First conversion after reset release: the first CLK edge with RESET_N=1 enters LOAD.
- Conversion time (16 cycles) is less than UPDATE_DIV, so a tick arriving while BUSY is only ever held in pending.

## Test plan
Benches use SCAN_DIV=4 and UPDATE_DIV=64.
- **Reset:** RESET_N=0 -> BCD=16'hFFFF, DECIMAL=0, OVER=0, BUSY=0, SCAN_CLK=0. After release, with MODE=00, FREQ=1234, FREQ_DP=2 -> 17 cycles later BCD=16'h1234, DECIMAL=2.
- **Conversion sweep:** FREQ ∈ {0, 9, 10, 999, 9999}, one per tick -> BCD ∈ {16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h9999}, OVER=0.
- **Saturation:** AMP=14'h3FFF with MODE=01 -> BCD=16'h9999, OVER=1. Then AMP=5000 -> BCD=16'h5000, OVER=0 at the next commit.
- **Mode and blank:** MODE 00→10 in mid-timer with DUTY=50, DUTY_DP=1 -> BCD=16'h0050, DECIMAL=1 within 17 cycles with no tick. Then MODE=11 -> BCD=16'hFFFF.
- **Pending collision:** change MODE while BUSY=1 -> the current conversion commits, and exactly one more conversion starts one idle cycle later using the new MODE.
- **Mid-conversion reset and scan clock:** assert RESET_N=0 during SHIFT -> outputs return to reset values at once. After release, SCAN_CLK toggles every 4 cycles (period 8).
